// File: rtl/clock_adjust_pkg.sv
// Shared types and helpers for the time-of-day adjust controller.
//   mode_e      : NORM (normal display) / ADJ (field adjust)
//   next_field  : field-select order, counts down from the LSB field
//                 and wraps to the most significant one
//   cnt_width   : width of a counter that must hold 0..max_val
package clock_adjust_pkg;

   typedef enum logic [0:0] {
      NORM = 1'b0,
      ADJ  = 1'b1
   } mode_e;

   localparam int NFIELD_DEF  = 3;
   localparam int TIMEOUT_DEF = 60;
   localparam int RPT_DLY_DEF = 50;
   localparam int RPT_PER_DEF = 10;

   function automatic int next_field(input int idx, input int nfield);
      return (idx == 0) ? nfield - 1 : idx - 1;
   endfunction

   // At least one bit, so a disabled (zero) limit still gives a legal vector.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/clock_adjust_ctrl_if.sv
// Key-input / field-control bundle between the key debouncers, the adjust
// controller and the clock datapath.
//   tick    : one-cycle timebase enable
//   sig2hz  : blink level
//   mode    : one-cycle pulse, enter/leave adjust
//   select  : one-cycle pulse, next field
//   adjust  : debounced adjust key level
//   down    : 1 = decrement, 0 = increment
//   inc/dec/clr : one-cycle per-field pulses to the field counters
//   on      : per-field display enable (0 blanks the digit)
//   adj_act : high while adjusting
// master drives the keys (key front-end / bench), slave is the controller.
interface clock_adjust_ctrl_if #(
   parameter int NFIELD = 3
);
   logic              tick;
   logic              sig2hz;
   logic              mode;
   logic              select;
   logic              adjust;
   logic              down;
   logic [NFIELD-1:0] inc;
   logic [NFIELD-1:0] dec;
   logic [NFIELD-1:0] clr;
   logic [NFIELD-1:0] on;
   logic              adj_act;

   modport master (
      output tick, sig2hz, mode, select, adjust, down,
      input  inc, dec, clr, on, adj_act
   );

   modport slave (
      input  tick, sig2hz, mode, select, adjust, down,
      output inc, dec, clr, on, adj_act
   );
endinterface

// File: rtl/clock_adjust_ctrl_tick_counter.sv
// tick_counter: up-counter advanced by i_en, saturating at i_term, with a
// synchronous clear that takes priority over counting.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : clear to 0
//   i_en           : count enable (normally the TICK pulse)
//   i_term         : terminal / saturation value
//   o_tc           : count equals i_term
module tick_counter #(
   parameter int W = 6
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_term,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != i_term)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/clock_adjust_ctrl.sv
// clock_adjust_ctrl: time-of-day adjust controller. MODE enters/leaves
// adjust, SELECT steps through NFIELD fields (0 -> NFIELD-1 -> ... -> 1),
// a rising edge of ADJUST issues one INC/DEC (or CLR for clear-masked
// fields) pulse to the selected field, and the selected digit blinks.
// Inactivity for TIMEOUT ticks returns to normal mode (TIMEOUT=0: never).
// Optional macro AUTO_REPEAT_EN: holding ADJUST repeats INC/DEC after
// RPT_DLY ticks, then every RPT_PER ticks (non-clear fields only).
// Ports:
//   i_clk   : system clock
//   i_rst_n : async active-low reset
//   bus     : clock_adjust_ctrl_if.slave (keys in, field controls out)
module clock_adjust_ctrl
   import clock_adjust_pkg::*;
#(
   parameter int              NFIELD   = NFIELD_DEF,
   parameter logic [NFIELD-1:0] CLR_MASK = NFIELD'(1),
   parameter int              TIMEOUT  = TIMEOUT_DEF,
   parameter int              RPT_DLY  = RPT_DLY_DEF,
   parameter int              RPT_PER  = RPT_PER_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   clock_adjust_ctrl_if.slave  bus
);

   // state | meaning
   // NORM  | normal time display, keys other than MODE ignored
   // ADJ   | adjusting field r_idx; selected digit blinks with SIG2HZ

   localparam int IDXW = $clog2(NFIELD);
   localparam int TOW  = cnt_width(TIMEOUT);

   if (NFIELD < 2 || NFIELD > 8 || TIMEOUT < 0 || RPT_DLY < 1 || RPT_PER < 1) begin : g_bad_cfg
      $error("clock_adjust_ctrl: parameter out of range");
   end

   mode_e             r_mode, w_mode_nxt;
   logic [IDXW-1:0]   r_idx, w_idx_nxt;
   logic              r_adj_q;
   logic [NFIELD-1:0] r_inc, r_dec, r_clr;
   logic [NFIELD-1:0] w_inc_nxt, w_dec_nxt, w_clr_nxt;

   logic              w_in_adj;
   logic [NFIELD-1:0] w_sel_onehot;
   logic              w_field_clr;
   logic              w_adj_evt;
   logic              w_rpt_fire;
   logic              w_key;
   logic              w_to_tc;
   logic              w_to_expire;

   assign w_in_adj     = (r_mode == ADJ);
   assign w_sel_onehot = NFIELD'(1) << r_idx;
   assign w_field_clr  = |(CLR_MASK & w_sel_onehot);

   // A press coinciding with MODE/SELECT is dropped; the state change wins.
   assign w_adj_evt = w_in_adj & bus.adjust & ~r_adj_q & ~bus.mode & ~bus.select;
   assign w_key     = bus.mode | bus.select | w_adj_evt | w_rpt_fire;

   // Inactivity timer: held at 0 outside ADJ, restarted by any key activity.
   tick_counter #(.W(TOW)) u_timeout (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (~w_in_adj | w_key),
      .i_en    (bus.tick & w_in_adj),
      .i_term  (TOW'(TIMEOUT)),
      .o_tc    (w_to_tc)
   );

   assign w_to_expire = (TIMEOUT != 0) & w_to_tc;

`ifdef AUTO_REPEAT_EN
   localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
   localparam int RPW     = cnt_width(RPT_MAX);

   logic r_rpt_arm;
   logic r_rpt_per;
   logic w_arm_keep;
   logic w_rpt_run;
   logic w_rpt_tc;

   // Armed only by a press seen inside ADJ, so a key already held when
   // entering adjust never repeats.
   assign w_arm_keep = r_rpt_arm & w_in_adj & bus.adjust & ~bus.mode & ~bus.select;
   assign w_rpt_run  = w_arm_keep & ~w_field_clr;

   // Terminal is one below the interval: the firing TICK is the one that
   // would have stepped past it.
   tick_counter #(.W(RPW)) u_repeat (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (~w_rpt_run | w_rpt_fire),
      .i_en    (bus.tick),
      .i_term  (r_rpt_per ? RPW'(RPT_PER - 1) : RPW'(RPT_DLY - 1)),
      .o_tc    (w_rpt_tc)
   );

   assign w_rpt_fire = w_rpt_run & bus.tick & w_rpt_tc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rpt_arm <= 1'b0;
         r_rpt_per <= 1'b0;
      end else begin
         r_rpt_arm <= w_adj_evt | w_arm_keep;
         r_rpt_per <= w_rpt_run & (r_rpt_per | w_rpt_fire);
      end
   end
`else
   assign w_rpt_fire = 1'b0;
`endif

   always_comb begin
      w_mode_nxt = r_mode;
      w_idx_nxt  = r_idx;
      w_inc_nxt  = '0;
      w_dec_nxt  = '0;
      w_clr_nxt  = '0;

      case (r_mode)
         NORM: begin
            if (bus.mode) begin
               w_mode_nxt = ADJ;
               w_idx_nxt  = '0;
            end
         end
         ADJ: begin
            if (bus.mode) begin
               w_mode_nxt = NORM;
               w_idx_nxt  = '0;
            end else if (bus.select) begin
               w_idx_nxt = IDXW'(next_field(int'(r_idx), NFIELD));
            end else if (w_to_expire && !w_key) begin
               w_mode_nxt = NORM;
               w_idx_nxt  = '0;
            end
         end
      endcase

      if (w_adj_evt || w_rpt_fire) begin
         if (w_field_clr) begin
            w_clr_nxt = w_sel_onehot;
         end else if (bus.down) begin
            w_dec_nxt = w_sel_onehot;
         end else begin
            w_inc_nxt = w_sel_onehot;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mode  <= NORM;
         r_idx   <= '0;
         r_adj_q <= 1'b0;
         r_inc   <= '0;
         r_dec   <= '0;
         r_clr   <= '0;
      end else begin
         r_mode  <= w_mode_nxt;
         r_idx   <= w_idx_nxt;
         r_adj_q <= bus.adjust;
         r_inc   <= w_inc_nxt;
         r_dec   <= w_dec_nxt;
         r_clr   <= w_clr_nxt;
      end
   end

   assign bus.inc     = r_inc;
   assign bus.dec     = r_dec;
   assign bus.clr     = r_clr;
   assign bus.on      = ~(w_sel_onehot & {NFIELD{w_in_adj & bus.sig2hz}});
   assign bus.adj_act = w_in_adj;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
module tb_clock_adjust_ctrl;

   localparam int          NF       = 3;
   localparam logic [2:0]  CMASK    = 3'b001;
   localparam int          TOUT     = 5;
   localparam int          RDLY     = 3;
   localparam int          RPER     = 2;
`ifdef AUTO_REPEAT_EN
   localparam bit          RPT_ON   = 1'b1;
`else
   localparam bit          RPT_ON   = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   clock_adjust_ctrl_if #(.NFIELD(NF)) bus ();

   clock_adjust_ctrl #(
      .NFIELD   (NF),
      .CLR_MASK (CMASK),
      .TIMEOUT  (TOUT),
      .RPT_DLY  (RDLY),
      .RPT_PER  (RPER)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit m, s, a, d, t, g;
      logic [2:0] on;
      bit         act;
      logic [2:0] inc, dec, clr;
   } vec_t;

   vec_t vecs[21];

   // reference model state (plain integers, event-level rules)
   bit         m_adj;
   int         m_idx;
   bit         m_prev;
   int         m_idle;
   bit         m_armed;
   int         m_held;
   logic [2:0] m_inc, m_dec, m_clr;

   function automatic logic [12:0] obs();
      return {bus.on, bus.adj_act, bus.inc, bus.dec, bus.clr};
   endfunction

   function automatic logic [8:0] pulses();
      return {bus.inc, bus.dec, bus.clr};
   endfunction

   task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
      end
   endtask

   task automatic set_in(input bit m, s, a, d, t, g);
      bus.mode = m; bus.select = s; bus.adjust = a;
      bus.down = d; bus.tick = t; bus.sig2hz = g;
   endtask

   task automatic cyc(input bit m, s, a, d, t, g);
      @(negedge clk);
      set_in(m, s, a, d, t, g);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_adj = 0; m_idx = 0; m_prev = 0; m_idle = 0;
      m_armed = 0; m_held = 0; m_inc = '0; m_dec = '0; m_clr = '0;
   endtask

   function automatic logic [12:0] model_obs(input bit g);
      logic [2:0] on_e;
      on_e = (m_adj && g) ? ~(3'(1) << m_idx) : 3'b111;
      return {on_e, m_adj, m_inc, m_dec, m_clr};
   endfunction

   task automatic model_step(input bit m, s, a, d, t);
      bit edge_evt, fire, key, expired, clr_f, hold_ok;
      logic [2:0] oh;
      oh       = 3'(1) << m_idx;
      clr_f    = (CMASK & oh) != 0;
      edge_evt = m_adj && a && !m_prev && !m && !s;
      hold_ok  = m_adj && a && !m && !s;
      fire     = 0;
      if (RPT_ON && m_armed && hold_ok && !clr_f && t) begin
         m_held++;
         fire = (m_held == RDLY) || (m_held > RDLY && ((m_held - RDLY) % RPER) == 0);
      end
      key     = m || s || edge_evt || fire;
      expired = (TOUT != 0) && (m_idle >= TOUT);
      m_inc = '0; m_dec = '0; m_clr = '0;
      if (edge_evt || fire) begin
         if (clr_f)  m_clr = oh;
         else if (d) m_dec = oh;
         else        m_inc = oh;
      end
      if (edge_evt) begin
         m_armed = 1; m_held = 0;
      end else if (!hold_ok) begin
         m_armed = 0; m_held = 0;
      end
      if (!m_adj || key) m_idle = 0;
      else if (t && m_idle < TOUT) m_idle++;
      if (!m_adj) begin
         if (m) begin m_adj = 1; m_idx = 0; end
      end else if (m) begin
         m_adj = 0; m_idx = 0;
      end else if (s) begin
         m_idx = (m_idx == 0) ? NF - 1 : m_idx - 1;
      end else if (expired && !key) begin
         m_adj = 0; m_idx = 0;
      end
      m_prev = a;
   endtask

   initial begin
      bit ra, rm, rs, rd, rt, rg;
      bit hit;
      set_in(0, 0, 0, 0, 0, 0);

      //             m  s  a  d  t  g   on     act inc     dec     clr
      vecs[0]  = '{0, 0, 0, 0, 0, 1, 3'b111, 0, 3'b000, 3'b000, 3'b000};
      vecs[1]  = '{0, 1, 0, 0, 0, 1, 3'b111, 0, 3'b000, 3'b000, 3'b000};
      vecs[2]  = '{1, 0, 0, 0, 0, 1, 3'b110, 1, 3'b000, 3'b000, 3'b000};
      vecs[3]  = '{0, 1, 0, 0, 0, 1, 3'b011, 1, 3'b000, 3'b000, 3'b000};
      vecs[4]  = '{0, 1, 0, 0, 0, 1, 3'b101, 1, 3'b000, 3'b000, 3'b000};
      vecs[5]  = '{0, 0, 0, 0, 0, 0, 3'b111, 1, 3'b000, 3'b000, 3'b000};
      vecs[6]  = '{0, 0, 1, 0, 0, 1, 3'b101, 1, 3'b010, 3'b000, 3'b000};
      vecs[7]  = '{0, 0, 1, 0, 0, 1, 3'b101, 1, 3'b000, 3'b000, 3'b000};
      vecs[8]  = '{0, 0, 0, 1, 0, 1, 3'b101, 1, 3'b000, 3'b000, 3'b000};
      vecs[9]  = '{0, 0, 1, 1, 0, 1, 3'b101, 1, 3'b000, 3'b010, 3'b000};
      vecs[10] = '{0, 0, 0, 0, 0, 1, 3'b101, 1, 3'b000, 3'b000, 3'b000};
      vecs[11] = '{0, 1, 1, 0, 0, 1, 3'b110, 1, 3'b000, 3'b000, 3'b000};
      vecs[12] = '{0, 0, 0, 0, 0, 1, 3'b110, 1, 3'b000, 3'b000, 3'b000};
      vecs[13] = '{0, 0, 1, 0, 0, 1, 3'b110, 1, 3'b000, 3'b000, 3'b001};
      vecs[14] = '{0, 0, 0, 0, 0, 1, 3'b110, 1, 3'b000, 3'b000, 3'b000};
      vecs[15] = '{0, 1, 0, 0, 0, 1, 3'b011, 1, 3'b000, 3'b000, 3'b000};
      vecs[16] = '{1, 1, 0, 0, 0, 1, 3'b111, 0, 3'b000, 3'b000, 3'b000};
      vecs[17] = '{1, 0, 1, 0, 0, 1, 3'b110, 1, 3'b000, 3'b000, 3'b000};
      vecs[18] = '{0, 0, 1, 0, 0, 1, 3'b110, 1, 3'b000, 3'b000, 3'b000};
      vecs[19] = '{0, 0, 0, 0, 0, 1, 3'b110, 1, 3'b000, 3'b000, 3'b000};
      vecs[20] = '{1, 0, 0, 0, 0, 1, 3'b111, 0, 3'b000, 3'b000, 3'b000};

      // reset state
      do_reset();
      #1;
      chk("reset", 0, 16'(obs()), 16'({3'b111, 1'b0, 9'b0}));

      foreach (vecs[i]) begin
         cyc(vecs[i].m, vecs[i].s, vecs[i].a, vecs[i].d, vecs[i].t, vecs[i].g);
         chk("vec", i, 16'(obs()),
             16'({vecs[i].on, vecs[i].act, vecs[i].inc, vecs[i].dec, vecs[i].clr}));
      end

      // reset asserted mid-ADJ(2) while a press is being sampled
      do_reset();
      cyc(1, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 1);
      chk("rst_pre", 0, 16'(obs()), 16'({3'b011, 1'b1, 9'b0}));
      @(negedge clk);
      set_in(0, 0, 1, 0, 0, 1);
      #1 rst_n = 1'b0;
      #1 chk("rst_async", 0, 16'(obs()), 16'({3'b111, 1'b0, 9'b0}));
      @(posedge clk);
      #1 chk("rst_nopulse", 0, 16'(obs()), 16'({3'b111, 1'b0, 9'b0}));
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      // timeout: 5 idle TICKs in ADJ(0)
      cyc(1, 0, 0, 0, 0, 1);
      for (int i = 1; i <= TOUT; i++) begin
         cyc(0, 0, 0, 0, 1, 1);
         chk("to_tick", i, 16'(bus.adj_act), 16'(1));
         cyc(0, 0, 0, 0, 0, 1);
         chk("to_idle", i, 16'(bus.adj_act), 16'(i < TOUT));
      end

      // SELECT on the 4th TICK restarts the timer
      cyc(1, 0, 0, 0, 0, 1);
      for (int i = 1; i <= 3; i++) begin
         cyc(0, 0, 0, 0, 1, 1);
         cyc(0, 0, 0, 0, 0, 1);
      end
      cyc(0, 1, 0, 0, 1, 1);
      chk("to_sel", 0, 16'(obs()), 16'({3'b011, 1'b1, 9'b0}));
      for (int i = 1; i <= TOUT; i++) begin
         cyc(0, 0, 0, 0, 1, 1);
         cyc(0, 0, 0, 0, 0, 1);
         chk("to_rst_idle", i, 16'(bus.adj_act), 16'(i < TOUT));
      end

      // held ADJUST in ADJ(1): repeats at TICK 3,5,7,9 when enabled
      do_reset();
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      chk("rpt_press", 0, 16'(pulses()), 16'({3'b010, 6'b0}));
      for (int t = 1; t <= 9; t++) begin
         hit = RPT_ON && t >= RDLY && ((t - RDLY) % RPER) == 0;
         cyc(0, 0, 1, 0, 1, 0);
         chk("rpt_tick", t, 16'(pulses()), hit ? 16'({3'b010, 6'b0}) : 16'(0));
         cyc(0, 0, 1, 0, 0, 0);
         chk("rpt_gap", t, 16'(pulses()), 16'(0));
      end
      cyc(0, 0, 0, 0, 0, 0);
      chk("rpt_act", 0, 16'(bus.adj_act), 16'(RPT_ON));

      // clear-masked field: single CLR, no repeats
      do_reset();
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      chk("clr_press", 0, 16'(pulses()), 16'(9'b000_000_001));
      for (int t = 1; t <= 4; t++) begin
         cyc(0, 0, 1, 0, 1, 0);
         chk("clr_hold", t, 16'(pulses()), 16'(0));
         cyc(0, 0, 1, 0, 0, 0);
      end

      // randomized run against the reference model
      do_reset();
      ra = 0;
      for (int i = 0; i < 4000; i++) begin
         rm = ($urandom_range(0, 19) == 0);
         rs = ($urandom_range(0, 7) == 0);
         rt = ($urandom_range(0, 2) == 0);
         rd = 1'($urandom_range(0, 1));
         rg = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 11) == 0) ra = ~ra;
         @(negedge clk);
         set_in(rm, rs, ra, rd, rt, rg);
         model_step(rm, rs, ra, rd, rt);
         @(posedge clk);
         #1;
         chk("rand", i, 16'(obs()), 16'(model_obs(rg)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
